// File: rtl/decode_stage.sv
// ---------------------------------------------------------------------------
// decode_stage
//   Registered, handshaked RV32I decode stage between fetch and register-read.
//   One instruction word plus its PC is accepted per valid/ready transfer; the
//   decoded fields, per-field valid flags, a one-hot opcode class and an
//   illegal flag are presented one cycle later and held until consumed.
//
// Parameters
//   XLEN     width of pc_in/pc_out and of the sign-extended immediate (32/64)
//   SKID_EN  1: two-entry skid buffer, in_ready driven from a flop
//            0: single output register, in_ready combinational
//
// Ports
//   clk, rst            rising-edge clock, asynchronous active-high reset
//   flush               drops all held and in-flight entries at the edge
//   in_valid/in_ready   input handshake for instr and pc_in
//   out_valid/out_ready output handshake for the decoded entry
//   pc_out              PC of the decoded entry
//   rd, rs1, rs2        register indices (instr[11:7], [19:15], [24:20])
//   func3, func7        instr[14:12], instr[31:25]
//   imm                 sign-extended immediate
//   *_valid             field is meaningful for this instruction format
//   op_class            one-hot: LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE,
//                       OP_IMM, OP, FENCE, SYSTEM (bits 0..10)
//   illegal             unrecognised encoding
// ---------------------------------------------------------------------------
module decode_stage #(
  parameter int XLEN    = 32,
  parameter int SKID_EN = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] pc_in,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] pc_out,
  output logic [4:0]      rd,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [2:0]      func3,
  output logic [6:0]      func7,
  output logic [XLEN-1:0] imm,
  output logic            rd_valid,
  output logic            rs1_valid,
  output logic            rs2_valid,
  output logic            func3_valid,
  output logic            func7_valid,
  output logic            imm_valid,
  output logic [10:0]     op_class,
  output logic            illegal
);

  // Major opcodes, instr[6:2]
  localparam logic [4:0] OPC_LUI    = 5'b01101;
  localparam logic [4:0] OPC_AUIPC  = 5'b00101;
  localparam logic [4:0] OPC_JAL    = 5'b11011;
  localparam logic [4:0] OPC_JALR   = 5'b11001;
  localparam logic [4:0] OPC_BRANCH = 5'b11000;
  localparam logic [4:0] OPC_LOAD   = 5'b00000;
  localparam logic [4:0] OPC_STORE  = 5'b01000;
  localparam logic [4:0] OPC_OP_IMM = 5'b00100;
  localparam logic [4:0] OPC_OP     = 5'b01100;
  localparam logic [4:0] OPC_FENCE  = 5'b00011;
  localparam logic [4:0] OPC_SYSTEM = 5'b11100;

  // op_class bit positions
  localparam int C_LUI    = 0;
  localparam int C_AUIPC  = 1;
  localparam int C_JAL    = 2;
  localparam int C_JALR   = 3;
  localparam int C_BRANCH = 4;
  localparam int C_LOAD   = 5;
  localparam int C_STORE  = 6;
  localparam int C_OP_IMM = 7;
  localparam int C_OP     = 8;
  localparam int C_FENCE  = 9;
  localparam int C_SYSTEM = 10;

  // Field-valid flags, packed as {rd, rs1, rs2, func3, func7, imm}
  localparam logic [5:0] V_RD  = 6'b100000;
  localparam logic [5:0] V_RS1 = 6'b010000;
  localparam logic [5:0] V_RS2 = 6'b001000;
  localparam logic [5:0] V_F3  = 6'b000100;
  localparam logic [5:0] V_F7  = 6'b000010;
  localparam logic [5:0] V_IMM = 6'b000001;
  localparam logic [5:0] V_R   = V_RD | V_RS1 | V_RS2 | V_F3 | V_F7;
  localparam logic [5:0] V_I   = V_RD | V_RS1 | V_F3 | V_IMM;
  localparam logic [5:0] V_SB  = V_RS1 | V_RS2 | V_F3 | V_IMM;
  localparam logic [5:0] V_UJ  = V_RD | V_IMM;

  typedef struct packed {
    logic [XLEN-1:0]        pc;
    logic [4:0]             rd;
    logic [4:0]             rs1;
    logic [4:0]             rs2;
    logic [2:0]             func3;
    logic [6:0]             func7;
    logic signed [XLEN-1:0] imm;
    logic [5:0]             vflags;
    logic [10:0]            op_class;
    logic                   illegal;
  } entry_t;

  // Every immediate is first assembled as a 32-bit signed value; widening
  // the signed value to XLEN replicates instr[31] (this also covers U-type
  // on XLEN=64).
  function automatic logic signed [XLEN-1:0] sext32(input logic signed [31:0] v);
    return v;
  endfunction

  function automatic logic signed [XLEN-1:0] imm_i(input logic [31:0] i);
    return sext32({{20{i[31]}}, i[31:20]});
  endfunction

  function automatic logic signed [XLEN-1:0] imm_s(input logic [31:0] i);
    return sext32({{20{i[31]}}, i[31:25], i[11:7]});
  endfunction

  function automatic logic signed [XLEN-1:0] imm_b(input logic [31:0] i);
    return sext32({{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0});
  endfunction

  function automatic logic signed [XLEN-1:0] imm_u(input logic [31:0] i);
    return sext32({i[31:12], 12'b0});
  endfunction

  function automatic logic signed [XLEN-1:0] imm_j(input logic [31:0] i);
    return sext32({{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0});
  endfunction

  function automatic entry_t decode(input logic [31:0] i, input logic [XLEN-1:0] pc);
    entry_t e;
    e          = '0;
    e.pc       = pc;
    e.rd       = i[11:7];
    e.rs1      = i[19:15];
    e.rs2      = i[24:20];
    e.func3    = i[14:12];
    e.func7    = i[31:25];
    if (i[1:0] != 2'b11) begin
      e.illegal = 1'b1;
    end else begin
      unique case (i[6:2])
        OPC_LUI:    begin e.op_class[C_LUI]    = 1'b1; e.imm = imm_u(i); e.vflags = V_UJ; end
        OPC_AUIPC:  begin e.op_class[C_AUIPC]  = 1'b1; e.imm = imm_u(i); e.vflags = V_UJ; end
        OPC_JAL:    begin e.op_class[C_JAL]    = 1'b1; e.imm = imm_j(i); e.vflags = V_UJ; end
        OPC_JALR:   begin e.op_class[C_JALR]   = 1'b1; e.imm = imm_i(i); e.vflags = V_I;  end
        OPC_BRANCH: begin e.op_class[C_BRANCH] = 1'b1; e.imm = imm_b(i); e.vflags = V_SB; end
        OPC_LOAD:   begin e.op_class[C_LOAD]   = 1'b1; e.imm = imm_i(i); e.vflags = V_I;  end
        OPC_STORE:  begin e.op_class[C_STORE]  = 1'b1; e.imm = imm_s(i); e.vflags = V_SB; end
        OPC_OP_IMM: begin
          e.op_class[C_OP_IMM] = 1'b1;
          e.imm                = imm_i(i);
          // Shifts (func3 001/101) carry a func7-style qualifier in [31:25]
          e.vflags             = (i[13:12] == 2'b01) ? (V_I | V_F7) : V_I;
        end
        OPC_OP:     begin e.op_class[C_OP]     = 1'b1; e.vflags = V_R; end
        OPC_FENCE:  begin e.op_class[C_FENCE]  = 1'b1; e.imm = imm_i(i); e.vflags = V_I;  end
        OPC_SYSTEM: begin e.op_class[C_SYSTEM] = 1'b1; e.imm = imm_i(i); e.vflags = V_I;  end
        default:    e.illegal = 1'b1;
      endcase
    end
    return e;
  endfunction

  entry_t dec_p0;
  entry_t out_p1;
  entry_t skid_p1;
  logic   vld_p1;
  logic   skid_vld_p1;
  logic   accept;
  logic   slot_free;

  // ---- stage p0: combinational decode of the incoming word ----
  assign dec_p0    = decode(instr, pc_in);
  assign accept    = in_valid & in_ready;
  // Output register may load this edge: empty, or its entry is leaving
  assign slot_free = !vld_p1 | out_ready;

  generate
    if (SKID_EN != 0) begin : g_skid
      assign in_ready = !skid_vld_p1;
    end else begin : g_noskid
      assign in_ready = slot_free;
    end
  endgenerate

  // ---- stage p1: output register and skid entry ----
  // Without the skid buffer, accept implies slot_free, so the skid entry is
  // never loaded and the same control serves both configurations.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1      <= 1'b0;
      skid_vld_p1 <= 1'b0;
    end else if (flush) begin
      vld_p1      <= 1'b0;
      skid_vld_p1 <= 1'b0;
    end else if (slot_free) begin
      if (skid_vld_p1) begin
        vld_p1      <= 1'b1;
        skid_vld_p1 <= accept;
      end else begin
        vld_p1      <= accept;
      end
    end else if (accept) begin
      skid_vld_p1 <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_p1  <= '0;
      skid_p1 <= '0;
    end else if (!flush) begin
      if (slot_free) begin
        // Older skid entry always drains first to keep order
        if (skid_vld_p1) begin
          out_p1 <= skid_p1;
          if (accept) skid_p1 <= dec_p0;
        end else if (accept) begin
          out_p1 <= dec_p0;
        end
      end else if (accept) begin
        skid_p1 <= dec_p0;
      end
    end
  end

  assign out_valid = vld_p1;
  assign pc_out    = out_p1.pc;
  assign rd        = out_p1.rd;
  assign rs1       = out_p1.rs1;
  assign rs2       = out_p1.rs2;
  assign func3     = out_p1.func3;
  assign func7     = out_p1.func7;
  assign imm       = out_p1.imm;
  assign op_class  = out_p1.op_class;
  assign illegal   = out_p1.illegal;
  assign {rd_valid, rs1_valid, rs2_valid, func3_valid, func7_valid, imm_valid} = out_p1.vflags;

endmodule

// File: tb/tb_decode_stage.sv
// ---------------------------------------------------------------------------
// tb_decode_stage
//   Directed bench for decode_stage. Three instances: XLEN=32 with skid
//   buffer (main), XLEN=32 without skid buffer, XLEN=64 with skid buffer.
//   Inputs change 1 time unit after the rising edge; outputs are sampled
//   at that point as well.
// ---------------------------------------------------------------------------
module tb_decode_stage;

  logic clk = 1'b0;
  logic rst, flush;
  logic [31:0] instr, pc;

  // main instance (XLEN=32, SKID_EN=1)
  logic in_valid, out_ready;
  logic in_ready, out_valid, illegal;
  logic [31:0] pc_out, imm;
  logic [4:0] rd, rs1, rs2;
  logic [2:0] func3;
  logic [6:0] func7;
  logic rd_v, rs1_v, rs2_v, f3_v, f7_v, imm_v;
  logic [10:0] op_class;
  logic [5:0] vf;
  assign vf = {rd_v, rs1_v, rs2_v, f3_v, f7_v, imm_v};

  // no-skid instance
  logic in_valid0, out_ready0;
  logic in_ready0, out_valid0, illegal0;
  logic [31:0] pc_out0, imm0;
  logic [4:0] rd0, rs10, rs20;
  logic [2:0] func30;
  logic [6:0] func70;
  logic rd_v0, rs1_v0, rs2_v0, f3_v0, f7_v0, imm_v0;
  logic [10:0] op_class0;

  // XLEN=64 instance
  logic in_valid64, out_ready64;
  logic [63:0] pc64;
  logic in_ready64, out_valid64, illegal64;
  logic [63:0] pc_out64, imm64;
  logic [4:0] rd64, rs164, rs264;
  logic [2:0] func364;
  logic [6:0] func764;
  logic rd_v64, rs1_v64, rs2_v64, f3_v64, f7_v64, imm_v64;
  logic [10:0] op_class64;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  decode_stage #(.XLEN(32), .SKID_EN(1)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .pc_in(pc), .out_valid(out_valid), .out_ready(out_ready),
    .pc_out(pc_out), .rd(rd), .rs1(rs1), .rs2(rs2), .func3(func3), .func7(func7),
    .imm(imm), .rd_valid(rd_v), .rs1_valid(rs1_v), .rs2_valid(rs2_v),
    .func3_valid(f3_v), .func7_valid(f7_v), .imm_valid(imm_v),
    .op_class(op_class), .illegal(illegal));

  decode_stage #(.XLEN(32), .SKID_EN(0)) dut0 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid0), .in_ready(in_ready0),
    .instr(instr), .pc_in(pc), .out_valid(out_valid0), .out_ready(out_ready0),
    .pc_out(pc_out0), .rd(rd0), .rs1(rs10), .rs2(rs20), .func3(func30), .func7(func70),
    .imm(imm0), .rd_valid(rd_v0), .rs1_valid(rs1_v0), .rs2_valid(rs2_v0),
    .func3_valid(f3_v0), .func7_valid(f7_v0), .imm_valid(imm_v0),
    .op_class(op_class0), .illegal(illegal0));

  decode_stage #(.XLEN(64), .SKID_EN(1)) dut64 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid64), .in_ready(in_ready64),
    .instr(instr), .pc_in(pc64), .out_valid(out_valid64), .out_ready(out_ready64),
    .pc_out(pc_out64), .rd(rd64), .rs1(rs164), .rs2(rs264), .func3(func364), .func7(func764),
    .imm(imm64), .rd_valid(rd_v64), .rs1_valid(rs1_v64), .rs2_valid(rs2_v64),
    .func3_valid(f3_v64), .func7_valid(f7_v64), .imm_valid(imm_v64),
    .op_class(op_class64), .illegal(illegal64));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; instr = '0; pc = '0;
    in_valid = 1'b0; out_ready = 1'b0;
    in_valid0 = 1'b0; out_ready0 = 1'b0;
    in_valid64 = 1'b0; out_ready64 = 1'b0; pc64 = '0;

    // ---- reset state ----
    step(); step();
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_pc_out",    64'(pc_out),    64'd0);
    chk("rst_imm",       64'(imm),       64'd0);
    chk("rst_op_class",  64'(op_class),  64'd0);
    chk("rst_illegal",   64'(illegal),   64'd0);
    chk("rst_fields",    64'({rd, rs1, rs2, func3, func7, vf}), 64'd0);
    rst = 1'b0;
    chk("rst_in_ready",  64'(in_ready),  64'd1);

    // ---- single add, one-cycle latency ----
    out_ready = 1'b1; in_valid = 1'b1; instr = 32'h002080b3; pc = 32'h100;
    step();
    in_valid = 1'b0;
    chk("add_valid",    64'(out_valid), 64'd1);
    chk("add_class",    64'(op_class),  64'h100);
    chk("add_regs",     64'({rd, rs1, rs2}), 64'({5'd1, 5'd1, 5'd2}));
    chk("add_f3f7",     64'({func3, func7}), 64'd0);
    chk("add_vflags",   64'(vf),        64'b111110);
    chk("add_pc",       64'(pc_out),    64'h100);
    chk("add_illegal",  64'(illegal),   64'd0);
    step();
    chk("add_drained",  64'(out_valid), 64'd0);

    // ---- back-to-back addi / jal / addi ----
    in_valid = 1'b1; instr = 32'hfff38293; pc = 32'h104;
    step();
    chk("b2b0_valid", 64'(out_valid), 64'd1);
    chk("b2b0_rd",    64'({rd, rs1}), 64'({5'd5, 5'd7}));
    chk("b2b0_imm",   64'(imm),      64'hFFFFFFFF);
    chk("b2b0_class", 64'(op_class), 64'h080);
    chk("b2b0_vf",    64'(vf),       64'b110101);
    instr = 32'hffdff1ef; pc = 32'h108;
    step();
    chk("b2b1_valid", 64'(out_valid), 64'd1);
    chk("b2b1_rd",    64'(rd),       64'd3);
    chk("b2b1_imm",   64'(imm),      64'hFFFFFFFC);
    chk("b2b1_rs1v",  64'(rs1_v),    64'd0);
    chk("b2b1_class", 64'(op_class), 64'h004);
    chk("b2b1_vf",    64'(vf),       64'b100001);
    instr = 32'h00108093; pc = 32'h10c;
    step();
    in_valid = 1'b0;
    chk("b2b2_valid", 64'(out_valid), 64'd1);
    chk("b2b2_rd",    64'({rd, rs1}), 64'({5'd1, 5'd1}));
    chk("b2b2_imm",   64'(imm),      64'd1);
    chk("b2b2_pc",    64'(pc_out),   64'h10c);
    step();
    chk("b2b_drained", 64'(out_valid), 64'd0);

    // ---- skid buffer fill under backpressure, then ordered drain ----
    out_ready = 1'b0; in_valid = 1'b1; instr = 32'h00100093; pc = 32'h200;
    chk("skid_ready0", 64'(in_ready), 64'd1);
    step();
    chk("skid_ready1", 64'(in_ready), 64'd1);
    instr = 32'h00200113; pc = 32'h204;
    step();
    chk("skid_full",   64'(in_ready), 64'd0);
    chk("skid_hold0",  64'(pc_out),   64'h200);
    instr = 32'h00300193; pc = 32'h208;
    step();
    chk("skid_full2",  64'(in_ready), 64'd0);
    chk("skid_hold1",  64'({pc_out[15:0], 11'd0, rd}), 64'({16'h200, 11'd0, 5'd1}));
    chk("skid_holdv",  64'(out_valid), 64'd1);
    out_ready = 1'b1;
    step();
    chk("drain1_pc",   64'(pc_out),   64'h204);
    chk("drain1_imm",  64'(imm),      64'd2);
    chk("drain1_rdy",  64'(in_ready), 64'd1);
    step();
    in_valid = 1'b0;
    chk("drain2_pc",   64'(pc_out),   64'h208);
    chk("drain2_rd",   64'(rd),       64'd3);
    chk("drain2_vld",  64'(out_valid), 64'd1);
    step();
    chk("drain_empty", 64'(out_valid), 64'd0);

    // ---- illegal encodings ----
    in_valid = 1'b1; instr = 32'h00000000; pc = 32'h300;
    step();
    chk("ill0_valid", 64'(out_valid), 64'd1);
    chk("ill0_flag",  64'(illegal),   64'd1);
    chk("ill0_class", 64'(op_class),  64'd0);
    chk("ill0_vf",    64'(vf),        64'd0);
    instr = 32'h0000007f; pc = 32'h304;
    step();
    in_valid = 1'b0;
    chk("ill1_valid", 64'(out_valid), 64'd1);
    chk("ill1_flag",  64'(illegal),   64'd1);
    chk("ill1_class", 64'(op_class),  64'd0);
    chk("ill1_vf",    64'(vf),        64'd0);
    step();

    // ---- flush with two held entries, then with an input handshaking ----
    out_ready = 1'b0; in_valid = 1'b1; instr = 32'h00100093; pc = 32'h400;
    step();
    pc = 32'h404;
    step();
    chk("fl_full", 64'(in_ready), 64'd0);
    flush = 1'b1; pc = 32'h408;
    step();
    flush = 1'b0;
    chk("fl_out_valid", 64'(out_valid), 64'd0);
    chk("fl_in_ready",  64'(in_ready),  64'd1);
    pc = 32'h410;
    step();
    chk("fl2_loaded", 64'(out_valid), 64'd1);
    flush = 1'b1; pc = 32'h414;
    chk("fl2_hs_rdy", 64'(in_ready), 64'd1);
    step();
    flush = 1'b0;
    chk("fl2_out_valid", 64'(out_valid), 64'd0);
    chk("fl2_in_ready",  64'(in_ready),  64'd1);
    out_ready = 1'b1; instr = 32'h002080b3; pc = 32'h418;
    step();
    in_valid = 1'b0;
    chk("fl_next_valid", 64'(out_valid), 64'd1);
    chk("fl_next_pc",    64'(pc_out),    64'h418);
    chk("fl_next_class", 64'(op_class),  64'h100);
    step();
    chk("fl_next_drain", 64'(out_valid), 64'd0);

    // ---- no-skid configuration: combinational in_ready ----
    out_ready0 = 1'b0; in_valid0 = 1'b1; instr = 32'h00100093; pc = 32'h500;
    chk("ns_ready_empty", 64'(in_ready0), 64'd1);
    step();
    chk("ns_valid",       64'(out_valid0), 64'd1);
    chk("ns_ready_stall", 64'(in_ready0),  64'd0);
    pc = 32'h504; out_ready0 = 1'b1;
    #1;
    chk("ns_ready_comb",  64'(in_ready0),  64'd1);
    step();
    in_valid0 = 1'b0;
    chk("ns_b2b_pc",      64'(pc_out0),    64'h504);
    chk("ns_b2b_valid",   64'(out_valid0), 64'd1);
    step();
    chk("ns_drain",       64'(out_valid0), 64'd0);

    // ---- XLEN=64 immediates, wide PC, async reset mid-stall ----
    out_ready64 = 1'b1; in_valid64 = 1'b1; instr = 32'hfff38293; pc64 = 64'h1_0000_0000;
    step();
    chk("x64_imm_i", imm64,    64'hFFFF_FFFF_FFFF_FFFF);
    chk("x64_pc",    pc_out64, 64'h1_0000_0000);
    instr = 32'h800000b7; pc64 = 64'h1_0000_0004;
    step();
    chk("x64_imm_u",   imm64,            64'hFFFF_FFFF_8000_0000);
    chk("x64_u_class", 64'(op_class64),  64'h001);
    out_ready64 = 1'b0; instr = 32'h00108093; pc64 = 64'h1_0000_0008;
    step();
    in_valid64 = 1'b0;
    chk("x64_stall_valid", 64'(out_valid64), 64'd1);
    chk("x64_stall_full",  64'(in_ready64),  64'd0);
    chk("x64_stall_pc",    pc_out64,         64'h1_0000_0004);
    rst = 1'b1;
    #1;
    chk("x64_async_valid", 64'(out_valid64), 64'd0);
    chk("x64_async_ready", 64'(in_ready64),  64'd1);
    chk("x64_async_imm",   imm64,            64'd0);
    rst = 1'b0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
Registered, handshaked RV32I decode stage that supersedes the combinational decoder. It sits between fetch and register-read. It accepts one instruction word plus PC per valid/ready transfer and emits decoded fields, per-field valid flags, a one-hot opcode-class bus and an illegal flag one cycle later. Immediate width scales with XLEN, and an optional skid buffer gives full throughput under backpressure.

Parameters:
XLEN, 32, width of sign-extended imm and of pc_in/pc_out; legal values are 32 and 64.
SKID_EN, 1, 1 = two-entry skid buffer with registered in_ready; 0 = single output register with combinational in_ready.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  asynchronous, active-high reset.
flush  in  1  drops all held and in-flight entries.
in_valid  in  1  instr/pc_in valid.
in_ready  out  1  stage can accept.
instr  in  32  instruction word.
pc_in  in  XLEN  PC of instr.
out_valid  out  1  decoded entry valid.
out_ready  in  1  consumer accepts.
pc_out  out  XLEN  PC of decoded entry.
rd, rs1, rs2  out  5 each  register indices, taken as instr[11:7], [19:15], [24:20].
func3  out  3  instr[14:12].
func7  out  7  instr[31:25].
imm  out  XLEN  sign-extended immediate.
rd_valid, rs1_valid, rs2_valid, func3_valid, func7_valid, imm_valid  out  1 each  field meaningful.
op_class  out  11  one-hot, bits 0..10 = LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP_IMM, OP, FENCE, SYSTEM.
illegal  out  1  unrecognised encoding.

Behaviour:
- Reset (async, rst=1): out_valid=0, skid empty, all field outputs, imm, op_class and illegal =0, pc_out=0. in_ready=1 on the first cycle after rst deasserts.
- Transfer: input accepted when in_valid&in_ready at a clk edge. Output consumed when out_valid&out_ready. Latency: accepted at edge N → out_valid=1 after edge N, fields stable until consumed.
- Held outputs never change while out_valid=1 and out_ready=0.
- Field extraction is unconditional. Valid flags by format:
  - R (OP): rd, rs1, rs2, f3, f7.
  - I (OP_IMM, LOAD, JALR, SYSTEM, FENCE): rd, rs1, f3, imm. f7_valid additionally for OP_IMM with func3=001/101.
  - S (STORE), B (BRANCH): rs1, rs2, f3, imm.
  - U (LUI, AUIPC), J (JAL): rd, imm.
  - rd=x0 still gives rd_valid=1.
- Immediates, sign bit instr[31] extended to XLEN:
  - I = [31:20].
  - S = {[31:25],[11:7]}.
  - B = {[31],[7],[30:25],[11:8],0}.
  - U = {[31:12],12'b0}, sign-extended for XLEN=64.
  - J = {[31],[19:12],[20],[30:21],0}.
- illegal=1 when instr[1:0]!=2'b11 or opcode[6:2] is not one of the 11 classes. In that case op_class=0 and all valid flags=0. The entry still flows through the handshake.
- SKID_EN=0: in_ready = !out_valid | out_ready (combinational). No bubble on back-to-back transfers when out_ready=1.
- SKID_EN=1: in_ready = !skid_full (registered).
  - An input arriving while the output is stalled goes into the skid entry.
  - On output consumption the skid entry moves to the output in the same edge.
  - Order is strictly preserved. 100% throughput when out_ready=1. The entry count never exceeds 2.
- flush (synchronous, highest priority): at the edge, out_valid=0 and the skid is cleared. An input handshaking in the same cycle is discarded. in_ready is unaffected.
- rst asserted mid-transfer: entries are lost immediately with no partial output.

Test Plan:
- Reset, then instr=0x002080b3 (add): OP one-hot bit8; rd=1, rs1=1, rs2=2, f3=0, f7=0; rd/rs1/rs2/f3/f7 valid, imm_valid=0; one cycle latency.
- instr=0xfff38293 then 0xffdff1ef then 0x00108093 back-to-back, out_ready=1:
  - addi: rd=5, rs1=7, imm=0xFFFFFFFF.
  - jal: rd=3, imm=0xFFFFFFFC, rs1_valid=0.
  - addi: rd=1, rs1=1, imm=1.
  - out_valid high three consecutive cycles.
- SKID_EN=1, hold out_ready=0 with in_valid=1 streaming: two entries accepted, then in_ready=0. Release out_ready: outputs appear in order, no loss or duplication.
- instr=0x00000000 → illegal=1, op_class=0, all valid flags=0, out_valid=1. Same with 0x0000007F (unknown opcode).
- flush asserted with 2 entries held and an input handshaking that cycle → next cycle out_valid=0. Next accepted instruction appears normally.
- XLEN=64: instr=0xfff38293 → imm=0xFFFFFFFFFFFFFFFF. pc_in=0x1_0000_0000 passes to pc_out. Assert rst mid-stall → out_valid=0 immediately (asynchronous).
